// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter and multi-byte transaction sequencer for the spi_master
// byte engine: per grant, writes tx bytes then reads rx bytes under one chip select.
module spi_xfer_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 2
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_tx_len,
    input  logic [NUM_REQ*LEN_W-1:0] req_rx_len,
    input  logic [NUM_REQ*8-1:0]     req_tx_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       tx_pop,
    output logic [7:0]               rx_data,
    output logic [NUM_REQ-1:0]       rx_valid,
    output logic [NUM_REQ-1:0]       done,
    output logic                     spi_nCS_ctrl,
    output logic                     spi_wr_req,
    output logic [7:0]               spi_data_in,
    input  logic                     spi_wr_ack,
    input  logic [7:0]               spi_data_out
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned MAX_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned MAX_C = (MAX_A > CS_IDLE) ? MAX_A : CS_IDLE;
    localparam int unsigned TMR_W = $clog2(MAX_C + 1);

    localparam logic [IDX_W-1:0] IDX_ONE  = 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = 1;
    localparam logic [TMR_W-1:0] TMR_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_LOAD,
        S_WAIT_ACK,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] tx_pop_q, tx_pop_d;
    logic [NUM_REQ-1:0] rx_valid_q, rx_valid_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               ncs_q, ncs_d;
    logic               wr_req_q, wr_req_d;
    logic [7:0]         data_in_q, data_in_d;
    logic [LEN_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [LEN_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic               is_read_q, is_read_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic [LEN_W-1:0]   win_tx_len;
    logic [LEN_W-1:0]   win_rx_len;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_LAST) ? '0 : i + IDX_ONE;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan starts one past the previous winner, so the last owner ranks lowest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = next_idx(last_q);
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = next_idx(cand);
        end
    end

    assign win_tx_len = req_tx_len[win_idx*LEN_W +: LEN_W];
    assign win_rx_len = req_rx_len[win_idx*LEN_W +: LEN_W];

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        own_d      = own_q;
        grant_d    = grant_q;
        tx_pop_d   = '0;
        rx_valid_d = '0;
        done_d     = '0;
        rx_data_d  = rx_data_q;
        ncs_d      = ncs_q;
        wr_req_d   = wr_req_q;
        data_in_d  = data_in_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        is_read_d  = is_read_q;
        tmr_d      = tmr_q;

        unique case (state_q)
            S_IDLE: begin
                if (|req) state_d = S_ARB;
            end

            S_ARB: begin
                if (!win_found) begin
                    state_d = S_IDLE;
                end else begin
                    last_d   = win_idx;
                    own_d    = win_idx;
                    tx_cnt_d = win_tx_len;
                    rx_cnt_d = win_rx_len;
                    if (win_tx_len == '0 && win_rx_len == '0) begin
                        done_d  = onehot(win_idx);
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        grant_d = onehot(win_idx);
                        ncs_d   = 1'b0;
                        // LOAD itself is the final setup cycle, so SETUP runs CS_SETUP-1 cycles.
                        if (CS_SETUP > 1) begin
                            tmr_d   = TMR_W'(CS_SETUP - 2);
                            state_d = S_SETUP;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
            end

            S_SETUP: begin
                if (tmr_q == '0) state_d = S_LOAD;
                else             tmr_d   = tmr_q - TMR_ONE;
            end

            S_LOAD: begin
                if (tx_cnt_q != '0) begin
                    data_in_d = req_tx_data[own_q*8 +: 8];
                    tx_pop_d  = onehot(own_q);
                    tx_cnt_d  = tx_cnt_q - LEN_ONE;
                    is_read_d = 1'b0;
                end else begin
                    data_in_d = 8'hFF;
                    if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - LEN_ONE;
                    is_read_d = 1'b1;
                end
                wr_req_d = 1'b1;
                state_d  = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                if (spi_wr_ack) begin
                    wr_req_d = 1'b0;
                    if (is_read_q) begin
                        rx_data_d  = spi_data_out;
                        rx_valid_d = onehot(own_q);
                    end
                    if (tx_cnt_q != '0 || rx_cnt_q != '0) begin
                        state_d = S_LOAD;
                    end else begin
                        tmr_d   = TMR_W'(CS_HOLD - 1);
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (tmr_q == '0) begin
                    ncs_d   = 1'b1;
                    done_d  = onehot(own_q);
                    grant_d = '0;
                    tmr_d   = TMR_W'(CS_IDLE - 1);
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end

            S_GAP: begin
                if (tmr_q == '0) state_d = S_IDLE;
                else             tmr_d   = tmr_q - TMR_ONE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= IDX_LAST;
            own_q      <= '0;
            grant_q    <= '0;
            tx_pop_q   <= '0;
            rx_valid_q <= '0;
            done_q     <= '0;
            rx_data_q  <= '0;
            ncs_q      <= 1'b1;
            wr_req_q   <= 1'b0;
            data_in_q  <= 8'hFF;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            is_read_q  <= 1'b0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            own_q      <= own_d;
            grant_q    <= grant_d;
            tx_pop_q   <= tx_pop_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            ncs_q      <= ncs_d;
            wr_req_q   <= wr_req_d;
            data_in_q  <= data_in_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            is_read_q  <= is_read_d;
            tmr_q      <= tmr_d;
        end
    end

    assign grant        = grant_q;
    assign tx_pop       = tx_pop_q;
    assign rx_valid     = rx_valid_q;
    assign done         = done_q;
    assign rx_data      = rx_data_q;
    assign spi_nCS_ctrl = ncs_q;
    assign spi_wr_req   = wr_req_q;
    assign spi_data_in  = data_in_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: a spi_master responder model plus a
// negedge monitor that pops expected grants, MOSI bytes, rx bytes and dones.
module tb_spi_xfer_arbiter;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] req_tx_len = '0;
    logic [15:0] req_rx_len = '0;
    logic [15:0] req_tx_data;
    logic [1:0]  grant, tx_pop, rx_valid, done;
    logic [7:0]  rx_data;
    logic        spi_nCS_ctrl, spi_wr_req;
    logic [7:0]  spi_data_in;
    logic        spi_wr_ack = 1'b0;
    logic [7:0]  spi_data_out = '0;

    spi_xfer_arbiter #(
        .NUM_REQ (2),
        .LEN_W   (8),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .CS_IDLE (CS_IDLE)
    ) dut (
        .sys_clk     (clk),
        .rst         (rst),
        .req         (req),
        .req_tx_len  (req_tx_len),
        .req_rx_len  (req_rx_len),
        .req_tx_data (req_tx_data),
        .grant       (grant),
        .tx_pop      (tx_pop),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .done        (done),
        .spi_nCS_ctrl(spi_nCS_ctrl),
        .spi_wr_req  (spi_wr_req),
        .spi_data_in (spi_data_in),
        .spi_wr_ack  (spi_wr_ack),
        .spi_data_out(spi_data_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard queues
    logic [1:0]  exp_grant[$];
    logic [1:0]  exp_done[$];
    logic [7:0]  exp_mosi[$];
    logic [9:0]  exp_rx[$];      // {owner one-hot, byte}
    logic [7:0]  slave_rsp[$];

    // Show-ahead tx byte sources
    logic [7:0] txmem0 [256];
    logic [7:0] txmem1 [256];
    logic [7:0] tx_idx0 = '0;
    logic [7:0] tx_idx1 = '0;
    assign req_tx_data = {txmem1[tx_idx1], txmem0[tx_idx0]};

    // spi_master responder
    int slave_bytes  = 0;
    int slave_acks   = 0;
    int last_ack_cyc = 0;

    initial begin
        logic [7:0] rsp;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (spi_wr_req && !rst) begin
                slave_bytes++;
                if (exp_mosi.size() == 0) check("mosi_unexpected", {24'h0, spi_data_in}, 32'hFFFF_FFFF);
                else                      check("mosi", {24'h0, spi_data_in}, {24'h0, exp_mosi.pop_front()});
                rsp     = (slave_rsp.size() != 0) ? slave_rsp.pop_front() : 8'h00;
                aborted = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                end
                if (!aborted) begin
                    spi_wr_ack   = 1'b1;
                    spi_data_out = rsp;
                    last_ack_cyc = cyc;
                    slave_acks++;
                    @(negedge clk);
                    spi_wr_ack = 1'b0;
                end
            end
        end
    end

    // Monitor
    logic [1:0] grant_prev = '0;
    logic       ncs_prev = 1'b1;
    logic       wr_prev = 1'b0;
    int         fall_cyc = 0;
    int         rise_cyc = -1;
    int         bytes_in_txn = 0;
    bit         setup_pending = 1'b0;
    int         wr_rises = 0;
    int         ncs_low_cycles = 0;
    int         tx_pops0 = 0;
    int         tx_pops1 = 0;

    always @(negedge clk) begin
        if (rst) begin
            bytes_in_txn  = 0;
            setup_pending = 1'b0;
        end
        if (grant != 2'b00 && grant_prev == 2'b00) begin
            if (exp_grant.size() == 0) check("grant_unexpected", {30'h0, grant}, 32'h0);
            else                       check("grant", {30'h0, grant}, {30'h0, exp_grant.pop_front()});
        end
        if (rx_valid != 2'b00) begin
            if (exp_rx.size() == 0) begin
                check("rx_unexpected", {30'h0, rx_valid}, 32'h0);
            end else begin
                logic [9:0] e;
                e = exp_rx.pop_front();
                check("rx_valid_owner", {30'h0, rx_valid}, {30'h0, e[9:8]});
                check("rx_data", {24'h0, rx_data}, {24'h0, e[7:0]});
            end
        end
        if (done != 2'b00) begin
            if (exp_done.size() == 0) check("done_unexpected", {30'h0, done}, 32'h0);
            else                      check("done", {30'h0, done}, {30'h0, exp_done.pop_front()});
            if (bytes_in_txn > 0) begin
                check("cs_hold", cyc - (last_ack_cyc + 1), CS_HOLD);
                check("ncs_rise_at_done", {31'h0, spi_nCS_ctrl & ~ncs_prev}, 32'h1);
            end
            bytes_in_txn = 0;
        end
        if (ncs_prev && !spi_nCS_ctrl) begin
            fall_cyc      = cyc;
            setup_pending = 1'b1;
            if (rise_cyc >= 0) check("cs_idle_min", {31'h0, (cyc - rise_cyc) >= CS_IDLE}, 32'h1);
        end
        if (!ncs_prev && spi_nCS_ctrl) rise_cyc = cyc;
        if (!spi_nCS_ctrl) ncs_low_cycles++;
        if (spi_wr_req && !wr_prev) begin
            wr_rises++;
            bytes_in_txn++;
            if (setup_pending) begin
                check("cs_setup", cyc - fall_cyc, CS_SETUP);
                setup_pending = 1'b0;
            end
        end
        if (tx_pop != 2'b00) begin
            check("tx_pop_owner", {30'h0, tx_pop & ~grant}, 32'h0);
            if (tx_pop[0]) begin tx_pops0++; tx_idx0 = tx_idx0 + 8'd1; end
            if (tx_pop[1]) begin tx_pops1++; tx_idx1 = tx_idx1 + 8'd1; end
        end
        grant_prev = grant;
        ncs_prev   = spi_nCS_ctrl;
        wr_prev    = spi_wr_req;
    end

    // Waits at negedges for done[b] (kind 0) or grant[b] (kind 1)
    task automatic wait_sig(input int kind, input int b, input int budget, output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < budget) begin
            @(negedge clk);
            waited++;
            found = (kind == 0) ? done[b] : grant[b];
        end
        check((kind == 0) ? "wait_done" : "wait_grant", {31'h0, found}, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d_cyc, g_cyc, sb0, wr0, pop0, ack0, ncs0, dcount;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ncs", {31'h0, spi_nCS_ctrl}, 32'h1);
        check("rst_data_in", {24'h0, spi_data_in}, 32'hFF);
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_grant", {30'h0, grant}, 32'h0);
        check("rst_tx_pop", {30'h0, tx_pop}, 32'h0);
        check("rst_rx_valid", {30'h0, rx_valid}, 32'h0);
        check("rst_done", {30'h0, done}, 32'h0);
        check("rst_wr_req", {31'h0, spi_wr_req}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Round robin, both held, 1 tx byte each
        txmem0[0] = 8'h11; txmem0[1] = 8'h22;
        txmem1[0] = 8'h33; txmem1[1] = 8'h44;
        req_tx_len = {8'd1, 8'd1};
        req_rx_len = {8'd0, 8'd0};
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        exp_mosi.push_back(8'h11); exp_mosi.push_back(8'h33);
        exp_mosi.push_back(8'h22); exp_mosi.push_back(8'h44);
        exp_done.push_back(2'b01); exp_done.push_back(2'b10);
        exp_done.push_back(2'b01); exp_done.push_back(2'b10);
        req = 2'b11;
        wait_sig(0, 0, 200, n);
        wait_sig(0, 1, 200, n);
        wait_sig(0, 0, 200, n);
        wait_sig(0, 1, 200, n);
        req = 2'b00;

        // Write A5 then read two bytes
        @(negedge clk);
        txmem0[tx_idx0] = 8'hA5;
        req_tx_len = {8'd0, 8'd1};
        req_rx_len = {8'd0, 8'd2};
        pop0 = tx_pops0;
        exp_grant.push_back(2'b01);
        exp_mosi.push_back(8'hA5); exp_mosi.push_back(8'hFF); exp_mosi.push_back(8'hFF);
        slave_rsp.push_back(8'h00); slave_rsp.push_back(8'h3C); slave_rsp.push_back(8'hC3);
        exp_rx.push_back({2'b01, 8'h3C}); exp_rx.push_back({2'b01, 8'hC3});
        exp_done.push_back(2'b01);
        req = 2'b01;
        wait_sig(0, 0, 200, n);
        req = 2'b00;
        check("wr_rd_tx_pops", tx_pops0 - pop0, 1);

        // Zero-length transaction on requester 1
        repeat (4) @(negedge clk);
        req_tx_len = '0;
        req_rx_len = '0;
        wr0  = wr_rises;
        ncs0 = ncs_low_cycles;
        exp_done.push_back(2'b10);
        req = 2'b10;
        wait_sig(0, 1, 20, n);
        req = 2'b00;
        check("zero_len_done_latency", n, 2);
        repeat (4) @(negedge clk);
        check("zero_len_no_wr_req", wr_rises - wr0, 0);
        check("zero_len_ncs_high", ncs_low_cycles - ncs0, 0);

        // 255-byte write
        req_tx_len = {8'd0, 8'd255};
        req_rx_len = '0;
        for (int k = 0; k < 255; k++) begin
            logic [7:0] b;
            b = 8'(k) ^ 8'h5A;
            txmem0[tx_idx0 + 8'(k)] = b;
            exp_mosi.push_back(b);
        end
        wr0  = wr_rises;
        pop0 = tx_pops0;
        ack0 = slave_acks;
        exp_grant.push_back(2'b01);
        exp_done.push_back(2'b01);
        req = 2'b01;
        wait_sig(0, 0, 3000, n);
        req = 2'b00;
        repeat (8) @(negedge clk);
        check("len255_wr_req", wr_rises - wr0, 255);
        check("len255_acks", slave_acks - ack0, 255);
        check("len255_tx_pop", tx_pops0 - pop0, 255);

        // Reset during byte 2 of 4
        req_tx_len = {8'd0, 8'd4};
        txmem0[tx_idx0]        = 8'h01;
        txmem0[tx_idx0 + 8'd1] = 8'h02;
        exp_grant.push_back(2'b01);
        exp_mosi.push_back(8'h01); exp_mosi.push_back(8'h02);
        sb0 = slave_bytes;
        req = 2'b01;
        n = 0;
        while (slave_bytes < sb0 + 2 && n < 200) begin @(posedge clk); n++; end
        check("rst_test_reach_byte2", {31'h0, slave_bytes >= sb0 + 2}, 32'h1);
        #1 rst = 1'b1;
        req = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_ncs", {31'h0, spi_nCS_ctrl}, 32'h1);
        check("midrst_wr_req", {31'h0, spi_wr_req}, 32'h0);
        check("midrst_grant", {30'h0, grant}, 32'h0);
        check("midrst_done", {30'h0, done}, 32'h0);
        check("midrst_data_in", {24'h0, spi_data_in}, 32'hFF);
        dcount = 0;
        repeat (10) begin @(negedge clk); if (done != 2'b00) dcount++; end
        check("midrst_no_done", dcount, 0);

        // Re-request after reset: requester 0 first
        txmem0[tx_idx0] = 8'h77;
        txmem1[tx_idx1] = 8'h88;
        req_tx_len = {8'd1, 8'd1};
        req_rx_len = '0;
        exp_grant.push_back(2'b01);
        exp_mosi.push_back(8'h77);
        exp_done.push_back(2'b01);
        req = 2'b11;
        wait_sig(0, 0, 200, n);
        req = 2'b00;

        // req0 drops after grant, req1 arrives mid-transfer
        repeat (4) @(negedge clk);
        txmem0[tx_idx0]        = 8'hB0;
        txmem0[tx_idx0 + 8'd1] = 8'hB1;
        txmem1[tx_idx1]        = 8'hC0;
        req_tx_len = {8'd1, 8'd2};
        req_rx_len = {8'd0, 8'd1};
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        exp_mosi.push_back(8'hB0); exp_mosi.push_back(8'hB1);
        exp_mosi.push_back(8'hFF); exp_mosi.push_back(8'hC0);
        slave_rsp.push_back(8'h00); slave_rsp.push_back(8'h00); slave_rsp.push_back(8'h5A);
        exp_rx.push_back({2'b01, 8'h5A});
        exp_done.push_back(2'b01); exp_done.push_back(2'b10);
        sb0 = slave_bytes;
        req = 2'b01;
        wait_sig(1, 0, 20, n);
        req[0] = 1'b0;
        req_tx_len[7:0] = 8'd7;
        n = 0;
        while (slave_bytes < sb0 + 1 && n < 100) begin @(posedge clk); n++; end
        @(negedge clk);
        req[1] = 1'b1;
        wait_sig(0, 0, 200, n);
        d_cyc = cyc;
        wait_sig(1, 1, 50, n);
        g_cyc = cyc;
        check("grant1_after_gap", g_cyc - d_cyc, CS_IDLE + 2);
        wait_sig(0, 1, 200, n);
        req = 2'b00;

        repeat (10) @(negedge clk);
        check("left_grant", exp_grant.size(), 0);
        check("left_mosi", exp_mosi.size(), 0);
        check("left_rx", exp_rx.size(), 0);
        check("left_done", exp_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
